pc_serial_subtractor: RTL
=========================

Name: pc_serial_subtractor

Overview:
- Multi-cycle unsigned subtractor for word-aligned PC quantities. It takes operands in the PC<31:2> format (30 bits) and computes a − b.
- Used for backward branch-offset recovery and PC-distance checks. It is the inverse operation of the 30-bit PC ripple adder.
- Processes DIGIT bits per clock, least significant digit first, so the combinational path stays short.
- Uses a start/busy/done handshake and holds registered results until the next accepted start.

Parameters:
- WIDTH, 30, operand/result width in bits; must be a positive multiple of DIGIT.
- DIGIT, 1, bits subtracted per RUN cycle; legal values are divisors of WIDTH (1, 2, 3, 5, 6, 10, 15, 30).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only on an edge where state is IDLE or DONE.
- a  input  WIDTH  minuend (PC<31:2>); sampled only on the accepting edge.
- b  input  WIDTH  subtrahend; sampled only on the accepting edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- d  output  WIDTH  registered difference, (a − b) mod 2^WIDTH.
- borrow  output  1  1 iff a < b (unsigned).
- zero  output  1  1 iff a == b.

Behaviour:
- Reset
  - Asserting rst_n=0 at any time, including mid-RUN, forces state IDLE immediately.
  - All outputs go to 0 and the internal shift registers and digit counter clear.
  - No done pulse is generated for an aborted operation.
- States: IDLE, RUN, DONE. The encoding is internal.
- Transitions
  - IDLE: start=1 → RUN and capture a, b. Otherwise stay in IDLE.
  - RUN: step the count each edge. On the (WIDTH/DIGIT)-th RUN edge → DONE.
  - DONE: start=1 → RUN and capture new operands (back-to-back accepted). Otherwise → IDLE.
- Arithmetic
  - Implemented as a + ~b + 1.
  - The carry flop is initialised to 1 on the accepting edge.
  - Each RUN edge consumes the low DIGIT bits of the operand shift registers with the current carry. It shifts the DIGIT sum bits into the result shifter from the MSB side and stores the carry-out.
  - After the final digit: borrow = ~carry_out, zero = (difference == 0).
  - The zero flag is computed from an OR-accumulator updated each digit, not a WIDTH-wide compare at the end.
- Result registers
  - d, borrow and zero update only on the final RUN edge.
  - They hold their values through DONE, IDLE and any later RUN until the next final RUN edge. Outputs are never partial.
- Latency
  - The accepting edge is E0. With N = WIDTH/DIGIT, busy=1 during cycles E0..E(N).
  - The final RUN edge EN sets done=1 and busy=0 for exactly one cycle.
  - DIGIT=1 gives N=30 RUN edges; DIGIT=5 gives N=6.
- start while busy: ignored. No queuing and no effect on the operation in flight.
- Operand changes on a or b after the accepting edge have no effect.
- busy and done are never high together.

Test Plan:
- Reset release, then a=30'h0000_0040, b=30'h0000_0010, start pulsed for 1 cycle → busy high for 30 cycles, then done for 1 cycle with d=30'h0000_0030, borrow=0, zero=0. Outputs are 0 before done.
- Borrow and wrap: a=30'h0000_0004, b=30'h0000_0008 → d=30'h3FFF_FFFC, borrow=1, zero=0. Also a=0, b=30'h3FFF_FFFF → d=30'h0000_0001, borrow=1.
- Equality and boundaries: a=b=30'h2AAA_AAAA → d=0, zero=1, borrow=0. Also a=30'h3FFF_FFFF, b=0 → d=30'h3FFF_FFFF, borrow=0.
- Back-to-back: assert start during the done cycle with new operands (100 − 1) → state goes DONE→RUN with no IDLE cycle. d holds the previous result until the second done, then d=99.
- Interference: toggle start and change a/b every cycle mid-RUN → the first result is unaffected and there is no extra done pulse. Drop rst_n at RUN cycle 15 → busy=0, d=0 immediately, and no done after release.
- Parameter sweep: DIGIT ∈ {1, 5, 30} on 1000 random operand pairs vs a reference model → d/borrow/zero match, and busy width = 30/DIGIT cycles.

Source files
------------

// File: rtl/pc_serial_subtractor.sv
// pc_serial_subtractor: digit-serial a - b on 30-bit PC<31:2> quantities, LSD first, start/busy/done handshake
//   clk, rst_n (async active-low)  | start, a, b (sampled on the accepting edge)
//   busy (RUN), done (1-cycle pulse) | d = (a-b) mod 2^WIDTH, borrow = a<b, zero = a==b
module pc_serial_subtractor #(
  parameter int WIDTH = 30,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t             state;
  logic [WIDTH-1:0]   sa, sb, sd, sd_next;
  logic [WIDTH+DIGIT-1:0] cat;
  logic [DIGIT:0]     sum;
  logic [CW-1:0]      cnt;
  logic               carry, nz, last, nz_next;
  // a + ~b + carry on the low digit; new sum bits enter the result shifter from the MSB side
  always_comb begin
    sum     = {1'b0, sa[DIGIT-1:0]} + {1'b0, ~sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    cat     = {sum[DIGIT-1:0], sd};
    sd_next = cat[WIDTH+DIGIT-1:DIGIT];
    nz_next = nz | (|sum[DIGIT-1:0]);
    last    = cnt == CW'(N - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      sd     <= '0;
      carry  <= 1'b0;
      nz     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            sa    <= a;
            sb    <= b;
            carry <= 1'b1;
            nz    <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sa    <= sa >> DIGIT;
          sb    <= sb >> DIGIT;
          sd    <= sd_next;
          carry <= sum[DIGIT];
          nz    <= nz_next;
          cnt   <= cnt + 1'b1;
          if (last) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            d      <= sd_next;
            borrow <= ~sum[DIGIT];
            zero   <= ~nz_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
